uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART_TX serializer among NUM_REQ requesters.
- Accepts one byte at a time from each requester, along with that requester's parity configuration.
- Drives the UART_TX P_DATA/Data_Valid/PAR_EN/PAR_TYP inputs and tracks UART_TX busy to find frame completion.
- Returns a per-requester completion ack, or an error pulse if the UART never starts the frame.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- P_DATA_WIDTH, 8, data width per frame; must match UART_TX.
- BUSY_TIMEOUT, 4, cycles allowed in WAIT_BUSY for tx_busy to rise (>=2).
- IDW (localparam), max(1,clog2(NUM_REQ)), requester index width.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous reset, active-low.
- req  input  NUM_REQ  level request per requester; held until its ack or err.
- req_data  input  NUM_REQ*P_DATA_WIDTH  requester i data in bits [i*P_DATA_WIDTH +: P_DATA_WIDTH].
- req_par_en  input  NUM_REQ  per-requester parity enable.
- req_par_typ  input  NUM_REQ  per-requester parity type (0 even, 1 odd).
- ack  output  NUM_REQ  one-hot, 1-cycle pulse: frame for requester i fully transmitted.
- err  output  1  1-cycle pulse: granted frame not started by UART (timeout).
- grant_id  output  IDW  index of current or last granted requester.
- arb_busy  output  1  high whenever state != IDLE.
- tx_p_data  output  P_DATA_WIDTH  to UART_TX P_DATA.
- tx_data_valid  output  1  to UART_TX Data_Valid.
- tx_par_en  output  1  to UART_TX PAR_EN.
- tx_par_typ  output  1  to UART_TX PAR_TYP.
- tx_busy  input  1  from UART_TX busy.

Behaviour:
- Reset (RST=0, async): state=IDLE; all outputs 0; priority pointer=0; timeout counter=0.
- All outputs are registered.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req bit is set and tx_busy=0, select the first set req at index >= pointer, wrapping modulo NUM_REQ.
  - On the next edge: load tx_p_data/tx_par_en/tx_par_typ from the winner; grant_id=winner; tx_data_valid=1; go to LAUNCH.
  - If tx_busy=1 in IDLE, do not grant.
- LAUNCH:
  - Lasts exactly 1 cycle; tx_data_valid=1 only in this cycle.
  - Next edge: tx_data_valid=0; counter=0; go to WAIT_BUSY.
- WAIT_BUSY:
  - If tx_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1 with tx_busy still 0: go to IDLE, pulse err for 1 cycle, no ack, pointer=grant_id+1 mod NUM_REQ.
- WAIT_DONE:
  - On the first cycle tx_busy=0: go to IDLE, ack[grant_id]=1 for 1 cycle, pointer=grant_id+1 mod NUM_REQ.
- tx_p_data, tx_par_en and tx_par_typ are held constant from LAUNCH until return to IDLE. Requester data changes mid-frame are ignored.
- The requester deasserts req in the cycle after it sees ack/err.
- The arbiter treats req bits as fresh in the IDLE cycle that follows ack, and may re-grant then, giving back-to-back frames.
- ack and err are never asserted together. ack is never asserted for a non-granted index.
- A requester deasserting req mid-frame does not abort the frame; ack is still issued.
- Fairness: with all req held, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 frames.
- arb_busy = (state != IDLE), registered with the state.
- Gap between frames: ack cycle (IDLE) -> next LAUNCH after 1 IDLE cycle.

Test Plan:
- Single request, no parity: req=0001, data0=8'hA5, par_en=0 -> tx_data_valid pulses 1 cycle with tx_p_data=A5; UART busy high ~10 cycles; ack=0001 one cycle after busy falls; S_DATA frame = 0,A5 LSB-first,1.
- Simultaneous requests: req=0110 from IDLE, pointer=0 -> requester 1 is sent first and acked, then requester 2; ack order 0010, 0100; grant_id 1 then 2.
- All four held: 8 frames, data0..3=11,22,33,44 -> tx_p_data sequence 11,22,33,44,11,22,33,44; each ack is one-hot and in order.
- Parity routing: req1 par_en=1 par_typ=1 data=8'h03 -> tx_par_en=1 and tx_par_typ=1 held through the frame; UART parity bit=1 (odd).
- Timeout: tx_busy tied 0, req=0001 -> err pulses once after BUSY_TIMEOUT cycles in WAIT_BUSY; ack stays 0; the next grant goes to the next set request at or after index 1.
- Reset mid-frame: assert RST=0 in WAIT_DONE -> all outputs 0 immediately; after release, state is IDLE, pointer=0, and no stray ack.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bundles the requester-side and UART_TX-side signals of the round-robin UART
// transmit arbiter. The slave modport is the arbiter; the master modport is its environment.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int P_DATA_WIDTH = 8
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ*P_DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]              req_par_en;
    logic [NUM_REQ-1:0]              req_par_typ;
    logic [NUM_REQ-1:0]              ack;
    logic                            err;
    logic [IDW-1:0]                  grant_id;
    logic                            arb_busy;
    logic [P_DATA_WIDTH-1:0]         tx_p_data;
    logic                            tx_data_valid;
    logic                            tx_par_en;
    logic                            tx_par_typ;
    logic                            tx_busy;

    modport slave (
        input  req, req_data, req_par_en, req_par_typ, tx_busy,
        output ack, err, grant_id, arb_busy,
               tx_p_data, tx_data_valid, tx_par_en, tx_par_typ
    );

    modport master (
        output req, req_data, req_par_en, req_par_typ, tx_busy,
        input  ack, err, grant_id, arb_busy,
               tx_p_data, tx_data_valid, tx_par_en, tx_par_typ
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART_TX serializer among NUM_REQ requesters,
// launching one byte per grant and reporting completion (ack) or a start timeout (err).
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int P_DATA_WIDTH = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input logic               CLK,
    input logic               RST,
    uart_tx_arbiter_if.slave  bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                  state_q;
    logic [IDW-1:0]          ptr_q;
    logic [IDW-1:0]          grant_q;
    logic [CW-1:0]           cnt_q;
    logic [NUM_REQ-1:0]      ack_q;
    logic                    err_q;
    logic                    arb_busy_q;
    logic                    data_valid_q;
    logic [P_DATA_WIDTH-1:0] p_data_q;
    logic                    par_en_q;
    logic                    par_typ_q;

    logic [2*NUM_REQ-1:0]    rot_d;
    logic [IDW:0]            off_d;
    logic [IDW:0]            sum_d;
    logic                    found_d;
    logic [IDW-1:0]          winner_d;
    logic [IDW-1:0]          next_ptr_d;
    logic [P_DATA_WIDTH-1:0] win_data_d;
    logic                    win_par_en_d;
    logic                    win_par_typ_d;
    logic                    cooldown_d;

    // Rotate the request vector so the pointer position becomes bit 0; the first set
    // bit then gives the offset of the round-robin winner from the pointer.
    always_comb begin
        rot_d   = {bus.req, bus.req} >> ptr_q;
        off_d   = '0;
        found_d = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_d && rot_d[k]) begin
                found_d = 1'b1;
                off_d   = (IDW+1)'(k);
            end
        end
        sum_d = {1'b0, ptr_q} + off_d;
        if (sum_d >= (IDW+1)'(NUM_REQ)) begin
            sum_d = sum_d - (IDW+1)'(NUM_REQ);
        end
        winner_d = sum_d[IDW-1:0];
    end

    always_comb begin
        win_data_d    = '0;
        win_par_en_d  = 1'b0;
        win_par_typ_d = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner_d == IDW'(k)) begin
                win_data_d    = bus.req_data[k*P_DATA_WIDTH +: P_DATA_WIDTH];
                win_par_en_d  = bus.req_par_en[k];
                win_par_typ_d = bus.req_par_typ[k];
            end
        end
    end

    always_comb begin
        next_ptr_d = (grant_q == IDW'(NUM_REQ-1)) ? '0 : grant_q + IDW'(1);
    end

    // The IDLE cycle carrying ack/err still sees the finished requester's old req,
    // so arbitration waits one more cycle for the request vector to settle.
    assign cooldown_d = (|ack_q) | err_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            cnt_q        <= '0;
            ack_q        <= '0;
            err_q        <= 1'b0;
            arb_busy_q   <= 1'b0;
            data_valid_q <= 1'b0;
            p_data_q     <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
        end else begin
            ack_q <= '0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found_d && !bus.tx_busy && !cooldown_d) begin
                        grant_q      <= winner_d;
                        p_data_q     <= win_data_d;
                        par_en_q     <= win_par_en_d;
                        par_typ_q    <= win_par_typ_d;
                        data_valid_q <= 1'b1;
                        arb_busy_q   <= 1'b1;
                        state_q      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    data_valid_q <= 1'b0;
                    cnt_q        <= '0;
                    state_q      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_q == CW'(BUSY_TIMEOUT-1)) begin
                        err_q      <= 1'b1;
                        ptr_q      <= next_ptr_d;
                        arb_busy_q <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        ack_q      <= NUM_REQ'(1) << grant_q;
                        ptr_q      <= next_ptr_d;
                        arb_busy_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack           = ack_q;
    assign bus.err           = err_q;
    assign bus.grant_id      = grant_q;
    assign bus.arb_busy      = arb_busy_q;
    assign bus.tx_p_data     = p_data_q;
    assign bus.tx_data_valid = data_valid_q;
    assign bus.tx_par_en     = par_en_q;
    assign bus.tx_par_typ    = par_typ_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a transaction-level model predicts every
// output each cycle while directed scenarios and random traffic drive requesters and a UART stub.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int PDW     = 8;
    localparam int BT      = 4;
    localparam int IDW     = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .P_DATA_WIDTH(PDW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .P_DATA_WIDTH (PDW),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        int         dvCount;
        int         dvCycle;
        logic [7:0] data;
        logic       parEn;
        logic       parTyp;
        int         grant;
        logic [3:0] ack;
        logic       err;
        int         busyCycles;
        int         lastTxBusy;
        int         endCycle;
        int         heldBad;
        logic       done;
    } frameT;

    int nCompared   = 0;
    int nMismatched = 0;
    int failPrinted = 0;
    int cyc         = 0;

    logic [NUM_REQ-1:0] reqV, parEnV, parTypV;
    logic [PDW-1:0]     dataV [NUM_REQ];
    int                 mode;
    int                 stubDelay, busyLeft, fixDelay, fixLen;
    logic               stubSilent;
    logic               sawDv;
    logic [NUM_REQ-1:0] sawEnd;

    // Transaction-level reference: a frame is either absent or in progress with an age
    // counted in cycles since launch; outcomes follow from busy observations and age.
    logic               mActive, mStarted, mCool, mEnded, mFound, mDv, mErr, mParEn, mParTyp;
    logic [NUM_REQ-1:0] mAck;
    logic [IDW-1:0]     mGrant;
    logic [PDW-1:0]     mData;
    int                 mAge, mPtr, mIdx, mWin;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mActive = 0; mStarted = 0; mCool = 0; mAge = 0; mPtr = 0;
            mGrant = '0; mAck = '0; mErr = 0; mDv = 0;
            mData = '0; mParEn = 0; mParTyp = 0;
        end else begin
            mEnded = 0;
            mAck   = '0;
            mErr   = 0;
            mDv    = 0;
            if (!mActive) begin
                if (!mCool && bus.req != '0 && !bus.tx_busy) begin
                    mFound = 0;
                    mWin   = 0;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        mIdx = (mPtr + k) % NUM_REQ;
                        if (!mFound && bus.req[mIdx]) begin
                            mFound = 1;
                            mWin   = mIdx;
                        end
                    end
                    mGrant   = IDW'(mWin);
                    mData    = bus.req_data[mWin*PDW +: PDW];
                    mParEn   = bus.req_par_en[mWin];
                    mParTyp  = bus.req_par_typ[mWin];
                    mActive  = 1;
                    mStarted = 0;
                    mAge     = 0;
                    mDv      = 1;
                end
            end else if (mAge == 0) begin
                mAge = 1;
            end else if (!mStarted) begin
                if (bus.tx_busy) mStarted = 1;
                else if (mAge == BT) begin mErr = 1; mEnded = 1; end
                else mAge = mAge + 1;
            end else if (!bus.tx_busy) begin
                mAck[mGrant] = 1'b1;
                mEnded = 1;
            end
            if (mEnded) begin
                mActive = 0;
                mPtr    = (int'(mGrant) + 1) % NUM_REQ;
            end
            mCool = mEnded;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        nCompared++;
        if (act !== expv) begin
            nMismatched++;
            if (failPrinted < 40) begin
                $display("[TB] FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
                failPrinted++;
            end
        end
    endtask

    task automatic pushInputs();
        bus.req         = reqV;
        bus.req_par_en  = parEnV;
        bus.req_par_typ = parTypV;
        for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*PDW +: PDW] = dataV[i];
    endtask

    // UART stand-in: after seeing Data_Valid it raises busy after a delay for a length.
    task automatic driveStub();
        if (bus.tx_busy) begin
            if (busyLeft > 0) busyLeft--;
            if (busyLeft == 0) bus.tx_busy = 1'b0;
        end else begin
            if (sawDv && !stubSilent) begin
                stubDelay = (fixDelay >= 0) ? fixDelay :
                            (($urandom % 10) < 7 ? 0 : int'($urandom_range(1, 5)));
                busyLeft  = (fixLen > 0) ? fixLen : int'($urandom_range(1, 12));
            end
            if (stubDelay == 0) begin
                bus.tx_busy = 1'b1;
                stubDelay   = -1;
            end else if (stubDelay > 0) begin
                stubDelay--;
            end
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mode == 0 || mode == 2) begin
                if (reqV[i] && sawEnd[i]) begin
                    reqV[i] = 1'b0;
                end else if (mode == 2 && !reqV[i]) begin
                    if ($urandom % 4 == 0) begin
                        reqV[i]    = 1'b1;
                        dataV[i]   = PDW'($urandom);
                        parEnV[i]  = 1'($urandom);
                        parTypV[i] = 1'($urandom);
                    end
                end else if (mode == 2) begin
                    if ($urandom % 16 == 0) dataV[i] = PDW'($urandom);
                    if ($urandom % 16 == 0) parTypV[i] = ~parTypV[i];
                    if ($urandom % 97 == 0) reqV[i] = 1'b0;
                end
            end
        end
        pushInputs();
    endtask

    task automatic stepCycle();
        logic [63:0] act, expv;
        @(posedge CLK);
        #1;
        cyc++;
        driveStub();
        applyStimulus();
        @(negedge CLK);
        if (RST) begin
            act  = 64'({bus.ack, bus.err, bus.grant_id, bus.arb_busy, bus.tx_data_valid,
                        bus.tx_p_data, bus.tx_par_en, bus.tx_par_typ});
            expv = 64'({mAck, mErr, mGrant, mActive, mDv, mData, mParEn, mParTyp});
            checkOutput("cycle_model", act, expv);
        end
        sawDv  = bus.tx_data_valid;
        sawEnd = bus.ack | (bus.err ? (NUM_REQ'(1) << bus.grant_id) : '0);
    endtask

    task automatic runFrame(input int budget, output frameT f);
        f = '{default: 0};
        for (int n = 0; n < budget && !f.done; n++) begin
            stepCycle();
            if (bus.tx_data_valid) begin
                f.dvCount++;
                f.dvCycle = cyc;
                f.data    = bus.tx_p_data;
                f.parEn   = bus.tx_par_en;
                f.parTyp  = bus.tx_par_typ;
                f.grant   = int'(bus.grant_id);
            end else if (bus.arb_busy && f.dvCount > 0 &&
                         (bus.tx_p_data !== f.data || bus.tx_par_en !== f.parEn ||
                          bus.tx_par_typ !== f.parTyp)) begin
                f.heldBad++;
            end
            if (bus.arb_busy) f.busyCycles++;
            if (bus.tx_busy) f.lastTxBusy = cyc;
            if (bus.ack != '0 || bus.err) begin
                f.ack      = bus.ack;
                f.err      = bus.err;
                f.endCycle = cyc;
                f.done     = 1'b1;
            end
        end
        checkOutput("frame_done", 64'(f.done), 64'(1));
    endtask

    task automatic applyReset();
        RST = 1'b0;
        bus.tx_busy = 1'b0;
        busyLeft = 0; stubDelay = -1; sawDv = 0; sawEnd = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        frameT f, g, prev;
        int    hits;
        logic [63:0] act;

        reqV = '0; parEnV = '0; parTypV = '0;
        for (int i = 0; i < NUM_REQ; i++) dataV[i] = '0;
        mode = 0; fixDelay = 0; fixLen = 10; stubSilent = 0;
        stubDelay = -1; busyLeft = 0; sawDv = 0; sawEnd = '0;
        bus.tx_busy = 1'b0;
        pushInputs();
        #2;
        applyReset();

        act = 64'({bus.ack, bus.err, bus.grant_id, bus.arb_busy, bus.tx_data_valid,
                   bus.tx_p_data, bus.tx_par_en, bus.tx_par_typ});
        checkOutput("reset_outputs", act, 64'(0));

        // Single request, no parity, UART busy for 10 cycles.
        dataV[0] = 8'hA5; reqV = 4'b0001; pushInputs();
        runFrame(60, f);
        checkOutput("single_dv_count", 64'(f.dvCount), 64'(1));
        checkOutput("single_data", 64'(f.data), 64'(8'hA5));
        checkOutput("single_par_en", 64'(f.parEn), 64'(0));
        checkOutput("single_ack", 64'(f.ack), 64'(4'b0001));
        checkOutput("single_busy_cycles", 64'(f.busyCycles), 64'(12));
        checkOutput("single_ack_after_busy", 64'(f.endCycle - f.lastTxBusy), 64'(2));

        // Two simultaneous requests, served 1 then 2 back to back.
        dataV[1] = 8'h5C; dataV[2] = 8'h3E; reqV = 4'b0110; pushInputs();
        runFrame(60, f);
        runFrame(60, g);
        checkOutput("dual_first_grant", 64'(f.grant), 64'(1));
        checkOutput("dual_first_ack", 64'(f.ack), 64'(4'b0010));
        checkOutput("dual_second_grant", 64'(g.grant), 64'(2));
        checkOutput("dual_second_ack", 64'(g.ack), 64'(4'b0100));
        checkOutput("dual_gap", 64'(g.dvCycle - f.endCycle), 64'(2));

        // All four held from a fresh pointer: strict rotation over eight frames.
        applyReset();
        dataV[0] = 8'h11; dataV[1] = 8'h22; dataV[2] = 8'h33; dataV[3] = 8'h44;
        mode = 1; reqV = 4'b1111; pushInputs();
        prev = '{default: 0};
        for (int k = 0; k < 8; k++) begin
            runFrame(60, f);
            checkOutput("rot_data", 64'(f.data), 64'(8'h11 * ((k % 4) + 1)));
            checkOutput("rot_ack", 64'(f.ack), 64'(1 << (k % 4)));
            if (k > 0) checkOutput("rot_gap", 64'(f.dvCycle - prev.endCycle), 64'(2));
            prev = f;
        end
        mode = 0; reqV = '0; pushInputs();

        // Odd parity routed from requester 1 and held through the frame.
        dataV[1] = 8'h03; parEnV[1] = 1'b1; parTypV[1] = 1'b1; reqV = 4'b0010; pushInputs();
        runFrame(60, f);
        checkOutput("par_data", 64'(f.data), 64'(8'h03));
        checkOutput("par_en", 64'(f.parEn), 64'(1));
        checkOutput("par_typ", 64'(f.parTyp), 64'(1));
        checkOutput("par_held", 64'(f.heldBad), 64'(0));
        parEnV = '0; parTypV = '0;

        // UART never starts: err after the timeout window, pointer moves past requester 0.
        stubSilent = 1; dataV[0] = 8'h7E; reqV = 4'b0001; pushInputs();
        runFrame(40, f);
        checkOutput("to_err", 64'(f.err), 64'(1));
        checkOutput("to_ack", 64'(f.ack), 64'(0));
        checkOutput("to_busy_cycles", 64'(f.busyCycles), 64'(1 + BT));
        stubSilent = 0; mode = 1; reqV = 4'b1001; pushInputs();
        runFrame(60, g);
        checkOutput("to_next_grant", 64'(g.grant), 64'(3));
        mode = 0; reqV = '0; pushInputs();

        // UART busy while idle holds off the grant until busy drops.
        bus.tx_busy = 1'b1; busyLeft = 5;
        hits = cyc;
        reqV = 4'b0100; pushInputs();
        runFrame(60, f);
        checkOutput("busy_idle_hold", 64'(f.dvCycle - hits), 64'(6));

        // Reset in WAIT_DONE clears everything; afterwards no stray ack and pointer is 0.
        reqV = 4'b0010; pushInputs();
        hits = 0;
        for (int n = 0; n < 30 && hits < 3; n++) begin
            stepCycle();
            if (bus.arb_busy && bus.tx_busy && !bus.tx_data_valid) hits++;
        end
        checkOutput("reach_wait_done", 64'(hits), 64'(3));
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        act = 64'({bus.ack, bus.err, bus.grant_id, bus.arb_busy, bus.tx_data_valid,
                   bus.tx_p_data, bus.tx_par_en, bus.tx_par_typ});
        checkOutput("midframe_reset_outputs", act, 64'(0));
        bus.tx_busy = 1'b0; busyLeft = 0; stubDelay = -1; sawDv = 0; sawEnd = '0;
        reqV = '0; pushInputs();
        @(negedge CLK);
        RST = 1'b1;
        hits = 0;
        for (int n = 0; n < 15; n++) begin
            stepCycle();
            if (bus.ack != '0 || bus.err) hits++;
        end
        checkOutput("no_stray_ack", 64'(hits), 64'(0));
        mode = 1; reqV = 4'b1111; pushInputs();
        runFrame(60, f);
        checkOutput("post_reset_grant", 64'(f.grant), 64'(0));
        mode = 0; reqV = '0; pushInputs();

        // Random traffic with random UART start delays (including timeouts) and lengths.
        fixDelay = -1; fixLen = 0; mode = 2;
        repeat (3000) stepCycle();
        mode = 0; reqV = '0; pushInputs();
        repeat (40) stepCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
